// File: rtl/rf_pkg.sv
// Shared types and defaults for the register-file write path.
package rf_pkg;
   localparam int RF_WIDTH  = 32;
   localparam int RF_ADDR_W = 5;
   localparam logic [RF_ADDR_W-1:0] REG_ZERO = 5'd0;

   typedef logic [RF_ADDR_W-1:0] rf_addr_t;
   typedef logic [RF_WIDTH-1:0]  rf_data_t;

   typedef struct packed {
      rf_addr_t addr;
      rf_data_t data;
   } rf_wr_req_t;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester after ptr, wrapping.
module rr_arbiter #(
   parameter int NUM_REQ = 2
) (
   input  logic [NUM_REQ-1:0]         req,
   input  logic [$clog2(NUM_REQ)-1:0] ptr,
   input  logic                       en,
   output logic [NUM_REQ-1:0]         gnt,
   output logic [$clog2(NUM_REQ)-1:0] idx
);
   localparam int PW = $clog2(NUM_REQ);

   logic          found;
   logic [PW-1:0] cand;

   always_comb begin
      gnt   = '0;
      idx   = '0;
      found = 1'b0;
      cand  = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         cand = PW'((int'(ptr) + k) % NUM_REQ);
         if (en && !found && req[cand]) begin
            gnt[cand] = 1'b1;
            idx       = cand;
            found     = 1'b1;
         end
      end
   end
endmodule

// File: rtl/rf_write_arbiter.sv
// Round-robin arbitration of writeback sources onto the single RF write port,
// with a one-cycle registered write stage that is forwarded to both read ports.
module rf_write_arbiter
   import rf_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int WIDTH   = RF_WIDTH,
   parameter int DEPTH   = RF_ADDR_W
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     hold,
   input  logic [NUM_REQ-1:0]       req_valid,
   input  logic [NUM_REQ*DEPTH-1:0] req_addr,
   input  logic [NUM_REQ*WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]       req_ready,
   output logic                     rf_write,
   output logic [DEPTH-1:0]         rf_write_register,
   output logic [WIDTH-1:0]         rf_write_data,
   input  logic [DEPTH-1:0]         rd_addr_1,
   input  logic [DEPTH-1:0]         rd_addr_2,
   output logic                     fwd_hit_1,
   output logic                     fwd_hit_2,
   output logic [WIDTH-1:0]         fwd_data,
   output logic [15:0]              grant_count
);
   localparam int PW = $clog2(NUM_REQ);

   typedef struct packed {
      logic [DEPTH-1:0] addr;
      logic [WIDTH-1:0] data;
   } wr_t;

   logic [NUM_REQ-1:0] gnt;
   logic [PW-1:0]      gidx, rr_ptr_q, rr_ptr_d;
   logic               wr_en_q, wr_en_d, accept;
   wr_t                wr_q, wr_d, sel;
   logic [15:0]        cnt_q, cnt_d;

   // Gating with rst keeps ready low for the whole reset window, not just after the edge.
   rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
      .req (req_valid),
      .ptr (rr_ptr_q),
      .en  (rst & ~hold),
      .gnt (gnt),
      .idx (gidx)
   );

   assign req_ready = gnt;
   assign accept    = |(req_valid & gnt);
   assign sel.addr  = req_addr[gidx*DEPTH +: DEPTH];
   assign sel.data  = req_data[gidx*WIDTH +: WIDTH];

   always_comb begin
      rr_ptr_d = rr_ptr_q;
      wr_d     = wr_q;
      wr_en_d  = 1'b0;
      cnt_d    = cnt_q;
      if (accept) begin
         rr_ptr_d = gidx;
         wr_d     = sel;
         // x0 writes complete the handshake but never reach the register file
         wr_en_d  = (sel.addr != '0);
         if (wr_en_d && cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rr_ptr_q <= PW'(NUM_REQ - 1);
         wr_q     <= '0;
         wr_en_q  <= 1'b0;
         cnt_q    <= '0;
      end else begin
         rr_ptr_q <= rr_ptr_d;
         wr_q     <= wr_d;
         wr_en_q  <= wr_en_d;
         cnt_q    <= cnt_d;
      end
   end

   assign rf_write          = wr_en_q;
   assign rf_write_register = wr_q.addr;
   assign rf_write_data     = wr_q.data;
   assign grant_count       = cnt_q;
   assign fwd_data          = wr_q.data;
   assign fwd_hit_1         = wr_en_q && (rd_addr_1 == wr_q.addr) && (rd_addr_1 != '0);
   assign fwd_hit_2         = wr_en_q && (rd_addr_2 == wr_q.addr) && (rd_addr_2 != '0);
endmodule

// File: doc/rf_write_arbiter.md
Name: rf_write_arbiter

Overview:
Shares the single write port of the register file between NUM_REQ writeback sources (ALU result, load unit, ...) with a valid/ready handshake and round-robin fairness. Accepted writes are registered one cycle before they reach the register file. During that cycle the block also forwards in-flight data to the two read ports, so no stale value is read.

Parameters:
NUM_REQ, 2, number of writeback requesters (2..8)
WIDTH, 32, data width in bits
DEPTH, 5, register address width in bits

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-low reset
hold  input  1  pipeline stall; no grants while high
req_valid  input  NUM_REQ  requester i has a write pending
req_addr  input  NUM_REQ*DEPTH  destination register per requester, packed, i at [i*DEPTH +: DEPTH]
req_data  input  NUM_REQ*WIDTH  write data per requester, packed
req_ready  output  NUM_REQ  one-hot grant; transfer when valid&ready
rf_write  output  1  register file write enable
rf_write_register  output  DEPTH  register file write address
rf_write_data  output  WIDTH  register file write data
rd_addr_1  input  DEPTH  read address 1, snooped for forwarding
rd_addr_2  input  DEPTH  read address 2, snooped for forwarding
fwd_hit_1  output  1  rd_addr_1 matches the in-flight write
fwd_hit_2  output  1  rd_addr_2 matches the in-flight write
fwd_data  output  WIDTH  data of the in-flight write
grant_count  output  16  saturating count of accepted non-x0 writes

Behaviour:
- Reset (rst=0, asynchronous, also mid-transfer): rf_write=0, rf_write_register=0, rf_write_data=0, rr_ptr=NUM_REQ-1, grant_count=0. An in-flight write is dropped. req_ready is combinationally 0 while rst=0.
- Grant (combinational):
  - req_ready is all-zero when hold=1.
  - Otherwise, scan from index rr_ptr+1 modulo NUM_REQ and grant the first i with req_valid[i]=1.
  - At most one bit of req_ready is set.
  - req_ready never depends on req_addr or req_data.
- Handshake:
  - A requester holds valid, addr and data stable until ready.
  - Dropping valid before ready is legal and cancels the request.
- Accept (rising edge where req_valid[g]&req_ready[g]):
  - rr_ptr <= g.
  - rf_write_register <= req_addr[g]; rf_write_data <= req_data[g].
  - rf_write <= (req_addr[g]!=0). A write to x0 is acked but never issued.
  - grant_count increments when the write is non-x0 and saturates at 16'hFFFF.
- No accept: rf_write <= 0. Address and data registers keep their values.
- Latency:
  - Accept at edge N, rf_write is high during cycle N..N+1, and the register file captures the value at edge N+1.
  - Sustained throughput is one write per cycle.
- Fairness: rr_ptr moves only on an accept. A continuously valid requester is granted within NUM_REQ accepts.
- Forwarding:
  - fwd_hit_k = rf_write & (rd_addr_k == rf_write_register) & (rd_addr_k != 0).
  - fwd_data = rf_write_data.
  - Both are combinational.
- hold=1 together with a valid request: no accept, rr_ptr unchanged, and rf_write drops to 0 on the next edge.
- Simultaneous requests to the same address in consecutive cycles: both are issued in grant order, so the last granted value wins.
- State: the grant state is rr_ptr only, an implicit FSM of NUM_REQ states with transitions on accept. There are no other states.

Decomposition:
- Package rf_pkg:
  - localparam RF_WIDTH=32, RF_ADDR_W=5, REG_ZERO=5'd0
  - typedef rf_addr_t = logic[RF_ADDR_W-1:0]
  - typedef rf_data_t = logic[RF_WIDTH-1:0]
  - typedef struct rf_wr_req_t {addr, data}
- Sub-module rr_arbiter (NUM_REQ): req vector, rr_ptr and enable in; one-hot grant and encoded index out. Purely combinational. The pointer register stays in rf_write_arbiter.

Test Plan:
- Reset, then req_valid=2'b01, addr=5'd3, data=32'hDEAD_BEEF -> req_ready=2'b01; next cycle rf_write=1, rf_write_register=3, rf_write_data=32'hDEAD_BEEF; grant_count=1.
- Both valid continuously, addresses 4 and 5, for 6 cycles -> grants alternate 01,10,01,10,...; six writes issued; grant_count=6.
- Requester 0 writes addr=0, data=32'h1234 -> req_ready[0]=1; rf_write stays 0; grant_count unchanged.
- hold=1 for 3 cycles with both valid -> req_ready=0 throughout; rf_write=0 from the first held edge; rr_ptr unchanged; the grant order resumes where it stopped.
- Write to addr 7 is in flight, rd_addr_1=7, rd_addr_2=0 -> fwd_hit_1=1, fwd_hit_2=0, fwd_data equals the write data.
- Assert rst=0 asynchronously between edges while rf_write=1 -> rf_write, address, data and grant_count go to 0 immediately; after release the first grant goes to requester 0.
